access_ctrl_fsm: RTL and testbench

Parametrised door-access controller FSM, the next generation of the basic access-code checker.
- Captures a submitted code on a validate strobe and checks it against a configurable inclusive range.
- Opens the door for a programmable number of cycles.
- Counts consecutive failures and enters a timed lockout after a configurable number of them.
- Sits between the keypad front-end and the door actuator/status logic.

---
 rtl/access_ctrl_fsm_if.sv | 40 ++++
 rtl/access_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_access_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/access_ctrl_fsm_if.sv
// Keypad/door handshake bundle for access_ctrl_fsm.
// master = keypad/supervisor side, slave = controller side.
interface access_ctrl_fsm_if #(
  parameter int CODE_W = 4,
  parameter int FAIL_W = 2
);
  logic [CODE_W-1:0] access_code;
  logic              validate_code;
  logic              clear_alarm;
  logic              open_access_door;
  logic              deny_pulse;
  logic              lockout;
  logic              alarm;
  logic [FAIL_W-1:0] fail_count;
  logic [2:0]        state_out;

  modport master (
    output access_code,
    output validate_code,
    output clear_alarm,
    input  open_access_door,
    input  deny_pulse,
    input  lockout,
    input  alarm,
    input  fail_count,
    input  state_out
  );

  modport slave (
    input  access_code,
    input  validate_code,
    input  clear_alarm,
    output open_access_door,
    output deny_pulse,
    output lockout,
    output alarm,
    output fail_count,
    output state_out
  );
endinterface

// File: rtl/access_ctrl_fsm.sv
// Door-access controller: range check, timed grant, failure lockout.
// Optional latched alarm enabled by defining ACCESS_ALARM_EN.
module access_ctrl_fsm #(
  parameter int CODE_W      = 4,
  parameter int CODE_MIN    = 4,
  parameter int CODE_MAX    = 11,
  parameter int OPEN_CYCLES = 16,
  parameter int MAX_FAILS   = 3,
  parameter int FAIL_W      = 2,
  parameter int LOCK_CYCLES = 64,
  parameter int TIMER_W     = 8
) (
  input logic clk,
  input logic rst_n,
  access_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_GRANT = 3'd2,
    S_DENY  = 3'd3,
    S_LOCK  = 3'd4
  } state_e;

  localparam logic [CODE_W-1:0] CMIN =
    CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] CMAX =
    CODE_W'(CODE_MAX);
  localparam logic [FAIL_W-1:0] FMAX =
    FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] OPEN_END =
    TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_END =
    TIMER_W'(LOCK_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               in_range;

  logic door, deny, lock;

  assign in_range = (code_q >= CMIN) &&
                    (code_q <= CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      fail_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.validate_code) begin
          state_d = S_CHECK;
          code_d  = bus.access_code;
        end
      end
      S_CHECK: begin
        if (in_range) begin
          state_d = S_GRANT;
          fail_d  = '0;
        end else begin
          // saturate so the count can never pass the lockout threshold
          if (fail_q < FMAX) begin
            fail_d = fail_q + 1'b1;
          end
          if (fail_d == FMAX) begin
            state_d = S_LOCK;
          end else begin
            state_d = S_DENY;
          end
        end
      end
      S_GRANT: begin
        if (timer_q == OPEN_END) begin
          state_d = S_IDLE;
        end
      end
      S_DENY: begin
        state_d = S_IDLE;
      end
      S_LOCK: begin
        if (timer_q == LOCK_END) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // timer only runs while dwelling in a timed state
  always_comb begin
    timer_d = '0;
    if (state_d == state_q &&
        (state_q == S_GRANT ||
         state_q == S_LOCK)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    door = 1'b0;
    deny = 1'b0;
    lock = 1'b0;
    unique case (1'b1)
      (state_q == S_GRANT): door = 1'b1;
      (state_q == S_DENY):  deny = 1'b1;
      (state_q == S_LOCK):  lock = 1'b1;
      default: ;
    endcase
  end

  assign bus.open_access_door = door;
  assign bus.deny_pulse       = deny;
  assign bus.lockout          = lock;
  assign bus.fail_count       = fail_q;
  assign bus.state_out        = state_q;

`ifdef ACCESS_ALARM_EN
  logic alarm_q, alarm_d;

  // set on lockout entry wins over a same-edge clear
  always_comb begin
    alarm_d = alarm_q;
    if (bus.clear_alarm && state_q != S_LOCK) begin
      alarm_d = 1'b0;
    end
    if (state_q != S_LOCK && state_d == S_LOCK) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign bus.alarm = alarm_q;
`else
  logic unused_clear_alarm;

  assign unused_clear_alarm = bus.clear_alarm;
  assign bus.alarm          = 1'b0;
`endif

endmodule

// File: tb/tb_access_ctrl_fsm.sv
// Randomized + directed bench for access_ctrl_fsm.
// Outputs are checked each cycle against a behavioural model.
module tb_access_ctrl_fsm;

  localparam int OPEN = 16;
  localparam int LOCK = 64;
  localparam int MAXF = 3;
  localparam int CMIN = 4;
  localparam int CMAX = 11;
`ifdef ACCESS_ALARM_EN
  localparam int ALARM = 1;
`else
  localparam int ALARM = 0;
`endif

  // model phases (also the state_out values)
  localparam int P_IDLE  = 0;
  localparam int P_CHECK = 1;
  localparam int P_OPEN  = 2;
  localparam int P_DENY  = 3;
  localparam int P_LOCK  = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  access_ctrl_fsm_if #(.CODE_W(4), .FAIL_W(2)) bus ();

  access_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int m_mode, m_left, m_fails, m_code, m_alarm;
  int door_cnt, deny_cnt, lock_cnt;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = P_IDLE;
    m_left  = 0;
    m_fails = 0;
    m_code  = 0;
    m_alarm = 0;
  endtask

  task automatic model_edge(input int v, input int c,
                            input int clr);
    int prev;
    prev = m_mode;
    case (m_mode)
      P_IDLE: if (v != 0) begin
        m_code = c;
        m_mode = P_CHECK;
      end
      P_CHECK: begin
        if (m_code >= CMIN && m_code <= CMAX) begin
          m_fails = 0;
          m_mode  = P_OPEN;
          m_left  = OPEN;
        end else begin
          m_fails = m_fails + 1;
          if (m_fails == MAXF) begin
            m_mode = P_LOCK;
            m_left = LOCK;
          end else begin
            m_mode = P_DENY;
          end
        end
      end
      P_OPEN: begin
        m_left--;
        if (m_left == 0) m_mode = P_IDLE;
      end
      P_DENY: m_mode = P_IDLE;
      P_LOCK: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = P_IDLE;
          m_fails = 0;
        end
      end
      default: m_mode = P_IDLE;
    endcase
    if (clr != 0 && prev != P_LOCK) m_alarm = 0;
    if (prev != P_LOCK && m_mode == P_LOCK) m_alarm = 1;
  endtask

  task automatic check_all();
    chk("door", int'(bus.open_access_door),
        int'(m_mode == P_OPEN));
    chk("deny", int'(bus.deny_pulse),
        int'(m_mode == P_DENY));
    chk("lockout", int'(bus.lockout),
        int'(m_mode == P_LOCK));
    chk("fail_count", int'(bus.fail_count), m_fails);
    chk("state_out", int'(bus.state_out), m_mode);
    chk("alarm", int'(bus.alarm),
        (ALARM != 0) ? m_alarm : 0);
    if (bus.open_access_door === 1'b1) door_cnt++;
    if (bus.deny_pulse === 1'b1) deny_cnt++;
    if (bus.lockout === 1'b1) lock_cnt++;
  endtask

  task automatic cyc(input int v, input int c,
                     input int clr);
    bus.validate_code = (v != 0);
    bus.access_code   = 4'(c);
    bus.clear_alarm   = (clr != 0);
    @(posedge clk);
    model_edge(v, c, clr);
    @(negedge clk);
    check_all();
  endtask

  // reset asserted between edges; outputs must drop with no clock
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic clr_cnt();
    door_cnt = 0;
    deny_cnt = 0;
    lock_cnt = 0;
  endtask

  initial begin
    rst_n             = 1'b1;
    bus.validate_code = 1'b0;
    bus.access_code   = '0;
    bus.clear_alarm   = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // basic grant
    clr_cnt();
    cyc(1, 4, 0);
    repeat (20) cyc(0, 0, 0);
    chk("t1_door_cycles", door_cnt, 16);

    // two rejects then a grant at the upper bound
    clr_cnt();
    cyc(1, 3, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t2_fail1", int'(bus.fail_count), 1);
    cyc(1, 12, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t2_fail2", int'(bus.fail_count), 2);
    chk("t2_deny_cycles", deny_cnt, 2);
    chk("t2_no_door", door_cnt, 0);
    cyc(1, 11, 0);
    repeat (20) cyc(0, 0, 0);
    chk("t2_fail_clr", int'(bus.fail_count), 0);
    chk("t2_door_cycles", door_cnt, 16);

    // lockout with ignored strobes
    clr_cnt();
    repeat (3) begin
      cyc(1, 0, 0);
      repeat (3) cyc(0, 0, 0);
    end
    for (int k = 0; k < 60; k++) cyc(k % 2, 5, 0);
    repeat (10) cyc(0, 0, 0);
    chk("t3_lock_cycles", lock_cnt, 64);
    chk("t3_no_door", door_cnt, 0);
    chk("t3_fail_exit", int'(bus.fail_count), 0);
    chk("t3_alarm_held", int'(bus.alarm), ALARM);
    cyc(0, 0, 1);
    chk("t3_alarm_clr", int'(bus.alarm), 0);

    // held strobe, code changes after capture
    clr_cnt();
    cyc(1, 4, 0);
    repeat (16) cyc(1, 2, 0);
    chk("t4_door_now", int'(bus.open_access_door), 1);
    repeat (10) cyc(1, 2, 0);
    repeat (80) cyc(0, 0, 0);
    chk("t4_door_cycles", door_cnt, 16);

    // async reset mid-grant
    do_reset();
    cyc(1, 4, 0);
    repeat (9) cyc(0, 0, 0);
    chk("t5_door_before", int'(bus.open_access_door), 1);
    do_reset();
    chk("t5_door_async", int'(bus.open_access_door), 0);
    clr_cnt();
    cyc(1, 4, 0);
    repeat (20) cyc(0, 0, 0);
    chk("t5_door_cycles", door_cnt, 16);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc(int'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
